// File: rtl/mxv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mxv_sequencer
// Description : Control FSM for the matrix-vector processor. For a runtime
//               ROWS x COLS job it sequences operand pops, PE enables, per-row
//               result capture / accumulator clear, and result transmission.
//               Stalls on an empty operand FIFO and on a transmitter that is
//               not ready, waits PE_LAT cycles for the PE pipeline to drain.
// Ports       : clk, rst            - clock, async active-high reset
//               start, rows, cols   - job request and size (latched in IDLE)
//               in_empty, tx_ready  - operand FIFO empty, transmitter ready
//               pop, p_enable       - operand pop, PE multiply-accumulate
//               p_retro, push, clr  - row result capture/push, acc clear
//               pop_result,transmit - result FIFO pop, valid to transmitter
//               busy, done, err     - status (err sticky until next start)
//               row_idx, col_idx    - current row / column counters
// Revision    : 1.0 - initial release
// ============================================================================
module mxv_sequencer #(
    parameter int MAX_DIM = 8,
    parameter int PE_LAT  = 1,
    parameter int CNT_W   = $clog2(MAX_DIM + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rows,
    input  logic [CNT_W-1:0] cols,
    input  logic             in_empty,
    input  logic             tx_ready,
    output logic             pop,
    output logic             p_enable,
    output logic             p_retro,
    output logic             push,
    output logic             clr,
    output logic             pop_result,
    output logic             transmit,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] row_idx,
    output logic [CNT_W-1:0] col_idx
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD    = 3'd1;
    localparam logic [2:0] c_OP      = 3'd2;
    localparam logic [2:0] c_DRAIN   = 3'd3;
    localparam logic [2:0] c_RESULT  = 3'd4;
    localparam logic [2:0] c_TX_POP  = 3'd5;
    localparam logic [2:0] c_TX_SEND = 3'd6;
    localparam logic [2:0] c_DONE    = 3'd7;

    // With no PE latency the drain state is bypassed entirely.
    localparam logic [2:0] c_AFTER_OP = (PE_LAT == 0) ? c_RESULT : c_DRAIN;

    localparam int                  c_WAIT_W    = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = (PE_LAT > 0) ? c_WAIT_W'(PE_LAT - 1) : '0;
    localparam logic [CNT_W-1:0]    c_MAX       = CNT_W'(MAX_DIM);

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_rows;
    logic [CNT_W-1:0]    r_cols;
    logic [CNT_W-1:0]    r_row;
    logic [CNT_W-1:0]    r_col;
    logic [CNT_W-1:0]    r_tx;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_err;

    logic [CNT_W-1:0] w_col_nxt;
    logic [CNT_W-1:0] w_row_nxt;
    logic [CNT_W-1:0] w_tx_nxt;
    logic             w_size_bad;

    assign w_col_nxt  = r_col + CNT_W'(1);
    assign w_row_nxt  = r_row + CNT_W'(1);
    assign w_tx_nxt   = r_tx + CNT_W'(1);
    assign w_size_bad = (rows == '0) || (cols == '0) || (rows > c_MAX) || (cols > c_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_rows  <= '0;
            r_cols  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_tx    <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_rows <= rows;
                        r_cols <= cols;
                        r_row  <= '0;
                        r_col  <= '0;
                        r_tx   <= '0;
                        r_wait <= '0;
                        r_err  <= w_size_bad;
                        r_state <= w_size_bad ? c_DONE : c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (!in_empty) r_state <= c_OP;
                end
                c_OP: begin
                    r_col <= w_col_nxt;
                    if (w_col_nxt == r_cols) begin
                        r_wait  <= '0;
                        r_state <= c_AFTER_OP;
                    end else begin
                        r_state <= c_LOAD;
                    end
                end
                c_DRAIN: begin
                    if (r_wait == c_WAIT_LAST) r_state <= c_RESULT;
                    else                       r_wait  <= r_wait + c_WAIT_W'(1);
                end
                c_RESULT: begin
                    r_row <= w_row_nxt;
                    r_col <= '0;
                    if (w_row_nxt == r_rows) begin
                        r_tx    <= '0;
                        r_state <= c_TX_POP;
                    end else begin
                        r_state <= c_LOAD;
                    end
                end
                c_TX_POP: begin
                    r_state <= c_TX_SEND;
                end
                c_TX_SEND: begin
                    if (tx_ready) begin
                        r_tx    <= w_tx_nxt;
                        r_state <= (w_tx_nxt == r_rows) ? c_DONE : c_TX_POP;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the state register; pop and transmit also qualify on
    // the handshake input so a stall cycle never issues a transfer.
    assign pop        = (r_state == c_LOAD) && !in_empty;
    assign p_enable   = (r_state == c_OP);
    assign p_retro    = (r_state == c_RESULT);
    assign push       = (r_state == c_RESULT);
    assign clr        = (r_state == c_RESULT);
    assign pop_result = (r_state == c_TX_POP);
    assign transmit   = (r_state == c_TX_SEND) && tx_ready;
    assign busy       = (r_state != c_IDLE);
    assign done       = (r_state == c_DONE);
    assign err        = r_err;
    assign row_idx    = r_row;
    assign col_idx    = r_col;

endmodule
`default_nettype wire

// File: tb/tb_mxv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mxv_sequencer
// Description : Directed self-checking bench for mxv_sequencer. Three
//               instances (PE_LAT = 0, 1, 2) share the stimulus; each
//               scenario resets them and observes the instance it targets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mxv_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] rows_in;
    logic [3:0] cols_in;
    logic       in_empty;
    logic       tx_ready;

    logic [2:0] pop_a, pen_a, retro_a, push_a, clr_a, popr_a, tx_a, busy_a, done_a, err_a;
    logic [3:0] row_a [3];
    logic [3:0] col_a [3];

    int sel;
    int checks;
    int errors;
    int n_busy, n_pop, n_pen, n_retro, n_push, n_clr, n_popr, n_tx, n_done, done_at;

    logic       pop_s, pen_s, retro_s, push_s, clr_s, popr_s, tx_s, busy_s, done_s, err_s;
    logic [3:0] row_s, col_s;
    logic [9:0] vec_s;

    mxv_sequencer #(.MAX_DIM(8), .PE_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .rows(rows_in), .cols(cols_in),
        .in_empty(in_empty), .tx_ready(tx_ready),
        .pop(pop_a[0]), .p_enable(pen_a[0]), .p_retro(retro_a[0]), .push(push_a[0]),
        .clr(clr_a[0]), .pop_result(popr_a[0]), .transmit(tx_a[0]), .busy(busy_a[0]),
        .done(done_a[0]), .err(err_a[0]), .row_idx(row_a[0]), .col_idx(col_a[0])
    );

    mxv_sequencer #(.MAX_DIM(8), .PE_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .rows(rows_in), .cols(cols_in),
        .in_empty(in_empty), .tx_ready(tx_ready),
        .pop(pop_a[1]), .p_enable(pen_a[1]), .p_retro(retro_a[1]), .push(push_a[1]),
        .clr(clr_a[1]), .pop_result(popr_a[1]), .transmit(tx_a[1]), .busy(busy_a[1]),
        .done(done_a[1]), .err(err_a[1]), .row_idx(row_a[1]), .col_idx(col_a[1])
    );

    mxv_sequencer #(.MAX_DIM(8), .PE_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .rows(rows_in), .cols(cols_in),
        .in_empty(in_empty), .tx_ready(tx_ready),
        .pop(pop_a[2]), .p_enable(pen_a[2]), .p_retro(retro_a[2]), .push(push_a[2]),
        .clr(clr_a[2]), .pop_result(popr_a[2]), .transmit(tx_a[2]), .busy(busy_a[2]),
        .done(done_a[2]), .err(err_a[2]), .row_idx(row_a[2]), .col_idx(col_a[2])
    );

    assign pop_s   = pop_a[sel];
    assign pen_s   = pen_a[sel];
    assign retro_s = retro_a[sel];
    assign push_s  = push_a[sel];
    assign clr_s   = clr_a[sel];
    assign popr_s  = popr_a[sel];
    assign tx_s    = tx_a[sel];
    assign busy_s  = busy_a[sel];
    assign done_s  = done_a[sel];
    assign err_s   = err_a[sel];
    assign row_s   = row_a[sel];
    assign col_s   = col_a[sel];
    assign vec_s   = {pop_s, pen_s, retro_s, push_s, clr_s, popr_s, tx_s, busy_s, done_s, err_s};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters for the selected instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (busy_s)  n_busy  = n_busy + 1;
        if (pop_s)   n_pop   = n_pop + 1;
        if (pen_s)   n_pen   = n_pen + 1;
        if (retro_s) n_retro = n_retro + 1;
        if (push_s)  n_push  = n_push + 1;
        if (clr_s)   n_clr   = n_clr + 1;
        if (popr_s)  n_popr  = n_popr + 1;
        if (tx_s)    n_tx    = n_tx + 1;
        if (done_s) begin
            n_done  = n_done + 1;
            done_at = n_busy;
        end
    end

    task automatic clear_counts();
        n_busy = 0; n_pop = 0; n_pen = 0; n_retro = 0; n_push = 0;
        n_clr = 0; n_popr = 0; n_tx = 0; n_done = 0; done_at = 0;
    endtask

    task automatic do_reset();
        start = 1'b0; in_empty = 1'b0; tx_ready = 1'b1; rows_in = '0; cols_in = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_counts();
    endtask

    // Returns one cycle after the start edge (first job cycle, +1ns).
    task automatic start_job(input logic [3:0] r, input logic [3:0] c);
        @(posedge clk); #1;
        rows_in = r; cols_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL %s_timeout done not seen within %0d cycles", name, budget);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start = 1'b0; in_empty = 1'b0; tx_ready = 1'b1;
        rst = 1'b1;
        #3;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            checks++;
            if (vec_s !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %b want 0", i, vec_s);
            end
            checks++;
            if (row_s !== 4'd0 || col_s !== 4'd0) begin
                errors++;
                $display("FAIL reset_idx dut%0d got row %0d col %0d want 0 0", i, row_s, col_s);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        sel = 1;
        do_reset();
        start_job(4'd2, 4'd3);
        wait_done("basic", 100);
        checks++; if (n_busy !== 21) begin errors++; $display("FAIL basic_busy got %0d want 21", n_busy); end
        checks++; if (done_at !== 21) begin errors++; $display("FAIL basic_done_cycle got %0d want 21", done_at); end
        checks++; if (n_pop !== 6 || n_pen !== 6) begin errors++; $display("FAIL basic_pop_pen got %0d %0d want 6 6", n_pop, n_pen); end
        checks++; if (n_push !== 2 || n_clr !== 2 || n_retro !== 2) begin errors++; $display("FAIL basic_push_clr_retro got %0d %0d %0d want 2 2 2", n_push, n_clr, n_retro); end
        checks++; if (n_popr !== 2 || n_tx !== 2) begin errors++; $display("FAIL basic_popr_tx got %0d %0d want 2 2", n_popr, n_tx); end
        checks++; if (n_done !== 1 || err_s !== 1'b0) begin errors++; $display("FAIL basic_done_err got %0d %b want 1 0", n_done, err_s); end
        checks++; if (row_s !== 4'd2 || col_s !== 4'd0) begin errors++; $display("FAIL basic_idx got %0d %0d want 2 0", row_s, col_s); end
    endtask

    task automatic test_illegal();
        sel = 1;
        do_reset();
        start_job(4'd0, 4'd4);
        wait_done("illegal_rows0", 20);
        checks++; if (n_busy !== 1 || n_done !== 1) begin errors++; $display("FAIL illegal0_busy_done got %0d %0d want 1 1", n_busy, n_done); end
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL illegal0_err got %b want 1", err_s); end
        checks++; if (n_pop + n_pen + n_push !== 0) begin errors++; $display("FAIL illegal0_activity got %0d want 0", n_pop + n_pen + n_push); end
        clear_counts();
        start_job(4'd9, 4'd1);
        wait_done("illegal_rows9", 20);
        checks++; if (n_busy !== 1 || n_done !== 1) begin errors++; $display("FAIL illegal9_busy_done got %0d %0d want 1 1", n_busy, n_done); end
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL illegal9_err got %b want 1", err_s); end
        checks++; if (n_pop + n_pen + n_push !== 0) begin errors++; $display("FAIL illegal9_activity got %0d want 0", n_pop + n_pen + n_push); end
        // A legal job clears the sticky error.
        clear_counts();
        start_job(4'd1, 4'd1);
        wait_done("illegal_recover", 50);
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL illegal_err_clear got %b want 0", err_s); end
    endtask

    task automatic test_empty_stall();
        sel = 1;
        do_reset();
        in_empty = 1'b1;
        start_job(4'd1, 4'd2);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (n_pop !== 0) begin errors++; $display("FAIL stall_pop_low got %0d want 0", n_pop); end
        in_empty = 1'b0;
        wait_done("empty_stall", 60);
        checks++; if (n_busy !== 12) begin errors++; $display("FAIL stall_busy got %0d want 12", n_busy); end
        checks++; if (n_pop !== 2 || n_pen !== 2 || n_tx !== 1) begin errors++; $display("FAIL stall_counts got %0d %0d %0d want 2 2 1", n_pop, n_pen, n_tx); end
    endtask

    task automatic test_tx_stall();
        int k;
        sel = 0;
        do_reset();
        tx_ready = 1'b0;
        start_job(4'd2, 4'd1);
        k = 0;
        while (!popr_s && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++; if (!popr_s) begin errors++; $display("FAIL txs_popr_seen got 0 want 1"); end
        @(posedge clk); #1;
        // Second start mid-job with a different size must be ignored.
        rows_in = 4'd5; cols_in = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (n_tx !== 0) begin errors++; $display("FAIL txs_tx_low got %0d want 0", n_tx); end
        tx_ready = 1'b1;
        @(negedge clk);
        checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL txs_tx_on_ready got %b want 1", tx_s); end
        wait_done("tx_stall", 60);
        checks++; if (n_busy !== 16) begin errors++; $display("FAIL txs_busy got %0d want 16", n_busy); end
        checks++; if (n_tx !== 2 || n_push !== 2 || n_pen !== 2) begin errors++; $display("FAIL txs_counts got %0d %0d %0d want 2 2 2", n_tx, n_push, n_pen); end
        checks++; if (row_s !== 4'd2) begin errors++; $display("FAIL txs_row got %0d want 2", row_s); end
    endtask

    task automatic test_full();
        sel = 2;
        do_reset();
        start_job(4'd8, 4'd8);
        wait_done("full", 400);
        checks++; if (n_busy !== 169) begin errors++; $display("FAIL full_busy got %0d want 169", n_busy); end
        checks++; if (n_pen !== 64 || n_push !== 8 || n_tx !== 8) begin errors++; $display("FAIL full_counts got %0d %0d %0d want 64 8 8", n_pen, n_push, n_tx); end
        checks++; if (row_s !== 4'd8 || col_s !== 4'd0) begin errors++; $display("FAIL full_idx got %0d %0d want 8 0", row_s, col_s); end
    endtask

    task automatic test_reset_midjob();
        int k;
        int seen;
        sel = 1;
        do_reset();
        start_job(4'd2, 4'd3);
        k = 0; seen = 0;
        while (seen < 3 && k < 50) begin
            @(negedge clk);
            if (pen_s) seen++;
            k++;
        end
        checks++; if (seen != 3) begin errors++; $display("FAIL midrst_third_op got %0d want 3", seen); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (vec_s !== 10'b0) begin errors++; $display("FAIL midrst_outputs got %b want 0", vec_s); end
        checks++; if (row_s !== 4'd0 || col_s !== 4'd0) begin errors++; $display("FAIL midrst_idx got %0d %0d want 0 0", row_s, col_s); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_counts();
        start_job(4'd1, 4'd1);
        wait_done("midrst_rerun", 50);
        checks++; if (n_busy !== 7 || n_done !== 1) begin errors++; $display("FAIL midrst_rerun_busy got %0d %0d want 7 1", n_busy, n_done); end
        checks++; if (n_pen !== 1 || n_tx !== 1 || err_s !== 1'b0) begin errors++; $display("FAIL midrst_rerun_counts got %0d %0d %b want 1 1 0", n_pen, n_tx, err_s); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel = 1;
        rst = 1'b0;
        rows_in = '0;
        cols_in = '0;
        clear_counts();
        test_reset();
        test_basic();
        test_illegal();
        test_empty_stall();
        test_tx_stall();
        test_full();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
